// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   INST_ADDR_W / INST_W : instruction address and instruction word widths
//   RST_ENABLE           : level of rst that resets the block
//   if_state_e           : fetch FSM encoding (IF_FETCH, IF_OUT)
package inst_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;

  typedef enum logic {
    IF_FETCH = 1'b0,
    IF_OUT   = 1'b1
  } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: builds each 32-bit instruction from four
// little-endian byte reads on a shared byte-wide memory port and hands it
// to decode with a valid flag, honouring stall and jump redirects.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   stall_i          : decode cannot accept the presented instruction
//   jump_i           : redirect to jump_addr_i (flushes the current fetch)
//   jump_addr_i      : redirect target PC
//   mem_req_o        : byte read request (combinational)
//   mem_addr_o       : byte address of the request (combinational)
//   mem_grant_i      : request accepted this cycle
//   mem_rdata_i      : read byte, valid the cycle after a grant
//   pc_o, inst_o     : delivered PC / instruction word (registered)
//   inst_valid_o     : pc_o/inst_o hold an undelivered instruction
//
// State | meaning
//   IF_FETCH | issuing byte reads and collecting returned bytes
//   IF_OUT   | full word presented, waiting for decode to accept it
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   jump_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  output logic                   mem_req_o,
  output logic [INST_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_grant_i,
  input  logic [7:0]             mem_rdata_i,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o,
  output logic                   inst_valid_o
);

  if_state_e              state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]             icnt_q, icnt_d;
  logic [2:0]             rcnt_q, rcnt_d;
  logic [23:0]            buf_q, buf_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [INST_ADDR_W-1:0] pc_o_q, pc_o_d;
  logic [INST_W-1:0]      inst_q, inst_d;
  logic                   valid_q, valid_d;
  logic                   req;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    icnt_d    = icnt_q;
    rcnt_d    = rcnt_q;
    buf_d     = buf_q;
    rd_pend_d = FALSE;
    pc_o_d    = pc_o_q;
    inst_d    = inst_q;
    valid_d   = valid_q;
    req       = FALSE;

    unique case (state_q)
      IF_FETCH: begin
        // Request is also held low while rst is asserted so nothing is
        // issued in the reset cycle itself.
        req = (icnt_q < 3'd4) && !jump_i && (rst != RST_ENABLE);
        if (req && mem_grant_i) begin
          icnt_d    = icnt_q + 3'd1;
          rd_pend_d = TRUE;
        end
        if (rd_pend_q) begin
          rcnt_d = rcnt_q + 3'd1;
          case (rcnt_q)
            3'd0:    buf_d[7:0]   = mem_rdata_i;
            3'd1:    buf_d[15:8]  = mem_rdata_i;
            3'd2:    buf_d[23:16] = mem_rdata_i;
            default: begin
              inst_d  = {mem_rdata_i, buf_q};
              pc_o_d  = pc_q;
              valid_d = TRUE;
              state_d = IF_OUT;
            end
          endcase
        end
      end
      IF_OUT: begin
        if (!stall_i) begin
          valid_d = FALSE;
          pc_d    = pc_q + 32'd4;
          icnt_d  = 3'd0;
          rcnt_d  = 3'd0;
          state_d = IF_FETCH;
        end
      end
      default: state_d = IF_FETCH;
    endcase

    // A redirect wins over delivery and stall; clearing rd_pend drops the
    // byte still in flight from before the jump.
    if (jump_i) begin
      pc_d      = jump_addr_i;
      icnt_d    = 3'd0;
      rcnt_d    = 3'd0;
      rd_pend_d = FALSE;
      valid_d   = FALSE;
      state_d   = IF_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= IF_FETCH;
      pc_q      <= RESET_PC;
      icnt_q    <= 3'd0;
      rcnt_q    <= 3'd0;
      buf_q     <= 24'd0;
      rd_pend_q <= FALSE;
      pc_o_q    <= '0;
      inst_q    <= '0;
      valid_q   <= FALSE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      icnt_q    <= icnt_d;
      rcnt_q    <= rcnt_d;
      buf_q     <= buf_d;
      rd_pend_q <= rd_pend_d;
      pc_o_q    <= pc_o_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
    end
  end

  assign mem_req_o    = req;
  assign mem_addr_o   = pc_q + {29'd0, icnt_q};
  assign pc_o         = pc_o_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte memory responder plus per-scenario
// tasks with hand-computed expectations.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i;
  logic [7:0]  mem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  inst_fetch #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_grant_i  (mem_grant_i),
    .mem_rdata_i  (mem_rdata_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:511];
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;
  logic        pend;
  logic [31:0] pend_addr;
  int          n_cmp;
  int          n_bad;

  localparam logic [31:0] INST0   = 32'h00100513;
  localparam logic [31:0] INST1   = 32'h00200593;
  localparam logic [31:0] INST100 = 32'h003102B3;

  // One clock: inputs change just after the rising edge, the returned byte
  // answers the previous cycle's grant, outputs are sampled at the falling edge.
  task automatic step(input logic r, input logic s, input logic j,
                      input logic [31:0] ja, input logic g);
    @(posedge clk);
    #1;
    rst         = r;
    stall_i     = s;
    jump_i      = j;
    jump_addr_i = ja;
    mem_grant_i = g;
    mem_rdata_i = pend ? mem[pend_addr[8:0]] : 8'hEE;
    @(negedge clk);
    s_req     = mem_req_o;
    s_addr    = mem_addr_o;
    s_valid   = inst_valid_o;
    s_inst    = inst_o;
    s_pc      = pc_o;
    pend      = mem_req_o && g;
    pend_addr = mem_addr_o;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (s_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b exp 0", s_req); end
    n_cmp++;
    if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", s_valid); end
    n_cmp++;
    if (s_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h exp 0", s_pc); end
    n_cmp++;
    if (s_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst got %h exp 0", s_inst); end
  endtask

  task automatic test_basic();
    logic        er, ev;
    logic [31:0] ea;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      er = (c <= 3) || (c >= 6 && c <= 9);
      ea = (c <= 3) ? 32'(c) : 32'(c - 2);
      ev = (c == 5) || (c == 11);
      n_cmp++;
      if (s_req !== er) begin n_bad++; $display("FAIL basic_req c=%0d got %b exp %b", c, s_req, er); end
      if (er) begin
        n_cmp++;
        if (s_addr !== ea) begin n_bad++; $display("FAIL basic_addr c=%0d got %h exp %h", c, s_addr, ea); end
      end
      n_cmp++;
      if (s_valid !== ev) begin n_bad++; $display("FAIL basic_valid c=%0d got %b exp %b", c, s_valid, ev); end
      if (c == 5) begin
        n_cmp++;
        if (s_inst !== INST0) begin n_bad++; $display("FAIL basic_inst0 got %h exp %h", s_inst, INST0); end
        n_cmp++;
        if (s_pc !== 32'h0) begin n_bad++; $display("FAIL basic_pc0 got %h exp 0", s_pc); end
      end
      if (c == 11) begin
        n_cmp++;
        if (s_inst !== INST1) begin n_bad++; $display("FAIL basic_inst1 got %h exp %h", s_inst, INST1); end
        n_cmp++;
        if (s_pc !== 32'h4) begin n_bad++; $display("FAIL basic_pc1 got %h exp 4", s_pc); end
      end
    end
  endtask

  task automatic test_grant_gap();
    logic [31:0] ea;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, (c != 1));
      if (c <= 4) begin
        ea = (c <= 1) ? 32'(c) : 32'(c - 1);
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== ea) begin
          n_bad++; $display("FAIL gap_req c=%0d got %b/%h exp 1/%h", c, s_req, s_addr, ea);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (s_valid !== 1'b0) begin n_bad++; $display("FAIL gap_early_valid got %b exp 0", s_valid); end
      end
      if (c == 6) begin
        n_cmp++;
        if (s_valid !== 1'b1) begin n_bad++; $display("FAIL gap_valid got %b exp 1", s_valid); end
        n_cmp++;
        if (s_inst !== INST0) begin n_bad++; $display("FAIL gap_inst got %h exp %h", s_inst, INST0); end
      end
      if (c == 7) begin
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h4) begin
          n_bad++; $display("FAIL gap_next got %b/%h exp 1/4", s_req, s_addr);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(1'b0, (c >= 5 && c <= 7), 1'b0, 32'h0, 1'b1);
      if (c >= 5 && c <= 8) begin
        n_cmp++;
        if (s_valid !== 1'b1 || s_inst !== INST0 || s_pc !== 32'h0) begin
          n_bad++;
          $display("FAIL stall_hold c=%0d got %b/%h/%h exp 1/%h/0", c, s_valid, s_inst, s_pc, INST0);
        end
        n_cmp++;
        if (s_req !== 1'b0) begin n_bad++; $display("FAIL stall_req c=%0d got %b exp 0", c, s_req); end
      end
      if (c == 9) begin
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h4 || s_valid !== 1'b0) begin
          n_bad++; $display("FAIL stall_release got %b/%h/%b exp 1/4/0", s_req, s_addr, s_valid);
        end
      end
    end
  endtask

  task automatic test_jump_fetch();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(1'b0, 1'b0, (c == 2), 32'h100, 1'b1);
      if (c == 2 || c == 7) begin
        n_cmp++;
        if (s_req !== 1'b0) begin n_bad++; $display("FAIL jf_req_low c=%0d got %b exp 0", c, s_req); end
      end
      if (c >= 3 && c <= 6) begin
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 + 32'(c - 3)) begin
          n_bad++; $display("FAIL jf_addr c=%0d got %b/%h exp 1/%h", c, s_req, s_addr, 32'h100 + 32'(c - 3));
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (s_valid !== 1'b0) begin n_bad++; $display("FAIL jf_early_valid got %b exp 0", s_valid); end
      end
      if (c == 8) begin
        n_cmp++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_inst !== INST100) begin
          n_bad++; $display("FAIL jf_deliver got %b/%h/%h exp 1/100/%h", s_valid, s_pc, s_inst, INST100);
        end
      end
    end
  endtask

  task automatic test_jump_out();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      step(1'b0, (c == 5 || c == 6), (c == 6), 32'h100, 1'b1);
      if (c == 6) begin
        n_cmp++;
        if (s_valid !== 1'b1 || s_req !== 1'b0) begin
          n_bad++; $display("FAIL jo_c6 got %b/%b exp valid 1 req 0", s_valid, s_req);
        end
      end
      if (c >= 7 && c <= 11) begin
        n_cmp++;
        if (s_valid !== 1'b0) begin n_bad++; $display("FAIL jo_dropped c=%0d got %b exp 0", c, s_valid); end
      end
      if (c >= 7 && c <= 10) begin
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 + 32'(c - 7)) begin
          n_bad++; $display("FAIL jo_addr c=%0d got %b/%h exp 1/%h", c, s_req, s_addr, 32'h100 + 32'(c - 7));
        end
      end
      if (c == 12) begin
        n_cmp++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_inst !== INST100) begin
          n_bad++; $display("FAIL jo_deliver got %b/%h/%h exp 1/100/%h", s_valid, s_pc, s_inst, INST100);
        end
      end
    end
  endtask

  // Runs straight after test_jump_out, so pc_o/inst_o start non-zero.
  task automatic test_reset_mid();
    for (int c = 0; c < 9; c++) begin
      step((c == 2), 1'b0, 1'b0, 32'h0, 1'b1);
      if (c == 0) begin
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h104) begin
          n_bad++; $display("FAIL rm_start got %b/%h exp 1/104", s_req, s_addr);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (s_req !== 1'b0) begin n_bad++; $display("FAIL rm_req_in_reset got %b exp 0", s_req); end
      end
      if (c == 3) begin
        n_cmp++;
        if (s_valid !== 1'b0 || s_pc !== 32'h0 || s_inst !== 32'h0) begin
          n_bad++; $display("FAIL rm_cleared got %b/%h/%h exp 0/0/0", s_valid, s_pc, s_inst);
        end
      end
      if (c >= 3 && c <= 6) begin
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'(c - 3)) begin
          n_bad++; $display("FAIL rm_addr c=%0d got %b/%h exp 1/%h", c, s_req, s_addr, 32'(c - 3));
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_inst !== INST0) begin
          n_bad++; $display("FAIL rm_deliver got %b/%h/%h exp 1/0/%h", s_valid, s_pc, s_inst, INST0);
        end
      end
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    pend        = 1'b0;
    pend_addr   = 32'h0;
    rst         = 1'b1;
    stall_i     = 1'b0;
    jump_i      = 1'b0;
    jump_addr_i = 32'h0;
    mem_grant_i = 1'b0;
    mem_rdata_i = 8'h00;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0]     = 8'h13; mem[1]     = 8'h05; mem[2]     = 8'h10; mem[3]     = 8'h00;
    mem[4]     = 8'h93; mem[5]     = 8'h05; mem[6]     = 8'h20; mem[7]     = 8'h00;
    mem[9'h100] = 8'hB3; mem[9'h101] = 8'h02; mem[9'h102] = 8'h31; mem[9'h103] = 8'h00;

    test_reset();
    test_basic();
    test_grant_gap();
    test_stall();
    test_jump_fetch();
    test_jump_out();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the RV32I pipeline. Assembles each 32-bit instruction from four little-endian byte reads on the shared byte-wide memory port. Presents `pc_o`/`inst_o` with a valid flag to the IF/ID boundary, which feeds the decode stage. Honours the downstream stall and redirects to a new PC on jump/branch.

## Interface
- `RESET_PC`, default 32'h0: PC of the first fetch after reset.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous, active-high.
- `stall_i` input 1: downstream cannot accept an instruction this cycle.
- `jump_i` input 1: redirect request (pipeline flush).
- `jump_addr_i` input 32: redirect target PC.
- `mem_req_o` output 1: byte read request.
- `mem_addr_o` output 32: byte address of the request.
- `mem_grant_i` input 1: arbiter accepted the request this cycle.
- `mem_rdata_i` input 8: read byte, valid the cycle after a granted request.
- `pc_o` output 32: PC of the delivered instruction.
- `inst_o` output 32: delivered instruction word.
- `inst_valid_o` output 1: `pc_o`/`inst_o` hold a new instruction.

## Operation
- State: `pc` register, issue count `icnt` (0..4), receive count `rcnt` (0..4), 24-bit byte buffer, pending flag `rd_pend`, FSM {FETCH, OUT}.
- FETCH:
  - `mem_req_o` = (`icnt` < 4) && !`jump_i`; `mem_addr_o` = `pc` + `icnt` (32-bit wrap).
  - Each granted request increments `icnt` and sets `rd_pend` for the next cycle.
  - When `rd_pend` is set, `mem_rdata_i` is stored into byte lane `rcnt` and `rcnt` increments.
  - On the edge capturing byte 3: `inst_o` <= {byte3, buffer[23:0]}, `pc_o` <= `pc`, `inst_valid_o` <= 1, go to OUT.
- OUT:
  - `mem_req_o` = 0.
  - If !`stall_i`: the instruction is accepted. `inst_valid_o` <= 0, `pc` <= `pc`+4, counters cleared, go to FETCH.
  - If `stall_i`: all outputs hold.
- `mem_grant_i` is ignored while `mem_req_o` = 0. Grants may be withheld any number of cycles; the request and address stay stable until granted.
- `stall_i` does not pause FETCH; only delivery waits.
- Jump (priority over stall and delivery, any state):
  - `pc` <= `jump_addr_i`; `icnt`, `rcnt`, `rd_pend` cleared; `inst_valid_o` <= 0; next state FETCH.
  - A byte returning in the cycle after the jump is discarded.
  - An undelivered instruction in OUT is dropped.
  - No alignment check; `jump_addr_i` is used as-is.
- `inst_o`/`pc_o` keep their last value while `inst_valid_o` = 0.

## Timing
- Reset values: `pc` = `RESET_PC`, `pc_o` = 0, `inst_o` = 0, `inst_valid_o` = 0, `mem_req_o` = 0 during the reset cycle, state FETCH, counters 0, `rd_pend` 0.
- `mem_req_o`/`mem_addr_o` are combinational from registered state and `jump_i`; all other outputs are registered.
- With grant every cycle, cycle 0 = first request:
  - Requests in cycles 0–3; bytes arrive in cycles 1–4.
  - `inst_valid_o` is high in cycle 5.
  - The next request is in cycle 6, giving a 6-cycle period.
- Each withheld grant cycle adds one cycle of latency.
- Reset asserted mid-fetch aborts the fetch. The first request after reset deasserts is at `RESET_PC` in the next cycle; any in-flight byte is dropped.

## Structure
- Shared `defines.v` holds `InstAddrBus`/`InstBus` widths and the `RstEnable`, `True`/`False` constants. Add `IF_FETCH`/`IF_OUT` state encodings there.
- No sub-module: the counters, buffer and FSM form one module of roughly 150 lines.

## Test plan
- Reset, memory bytes 0x13,0x05,0x10,0x00 at 0..3, grant always high → requests to addr 0,1,2,3 in cycles 0–3; `inst_valid_o` = 1 in cycle 5 with `inst_o` = 0x00100513, `pc_o` = 0; request to addr 4 in cycle 6.
- Same stimulus, `mem_grant_i` low in cycle 1 → addr 1 presented in cycles 1–2; valid in cycle 6; `inst_o` unchanged.
- `stall_i` high cycles 5–7 → `inst_valid_o`, `inst_o`, `pc_o` held through cycle 8; request to addr 4 in cycle 9.
- `jump_i` with `jump_addr_i` = 0x100 in cycle 2 → `mem_req_o` = 0 in cycle 2; byte returning in cycle 3 ignored; requests 0x100..0x103 in cycles 3–6; valid in cycle 8 with `pc_o` = 0x100.
- `jump_i` in cycle 6 while OUT with `stall_i` high → `inst_valid_o` = 0 in cycle 7; stalled word never delivered; fetch starts at the target.
- `rst` high in cycle 2 mid-fetch → `inst_valid_o` = 0 and `pc_o` = 0 after the edge; first request after release is at `RESET_PC`.
